// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of mem_arbiter.
// The arbiter uses the slave view; requesters and the memory sit on the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              last_gnt;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, last_gnt
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           busy, last_gnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between fetch and data ports.
// Every transaction takes four states; all outputs come straight from flops.
//   state | meaning
//   IDLE  | sample requests, grant winner and latch its address/data/we
//   ACC   | memory access cycle (mem_en=1)
//   CAP   | capture mem_rdata into the winner's rdata register on reads
//   DONE  | one-cycle ack to the winner
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, CAP, DONE} state_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // data wins when it is alone, or when both ask and fetch was granted last
    gnt        = bus.d_req & (~bus.if_req | ~last_gnt_q);
    case (state_q)
      IDLE: begin
        if (bus.if_req | bus.d_req) begin
          win_d      = gnt;
          last_gnt_d = gnt;
          addr_d     = gnt ? bus.d_addr : bus.if_addr;
          we_d       = gnt & bus.d_we;
          wdata_d    = gnt ? bus.d_wdata : '0;
          state_d    = ACC;
        end
      end
      ACC: state_d = CAP;
      CAP: begin
        if (!we_q) begin
          if (win_q) d_rdata_d  = bus.mem_rdata;
          else       if_rdata_d = bus.mem_rdata;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en_d = (state_d == ACC);
  assign mem_we_d = (state_d == ACC) & we_d;
  assign if_ack_d = (state_d == DONE) & ~win_d;
  assign d_ack_d  = (state_d == DONE) & win_d;
  assign busy_d   = (state_d != IDLE);

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.last_gnt  = last_gnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, corner sequences, then random traffic
// checked against a transaction-timing model with a shadow memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memory with a preload side port
  logic [31:0] mem [0:255] = '{default: '0};
  logic [31:0] mem_q = '0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            mem_q <= mem[bus.mem_addr[9:2]];
    end
  end
  assign bus.mem_rdata = mem_q;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endfunction

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_idx = addr[9:2]; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int en_cnt,
                        output int we_cnt, output int other);
    @(posedge clk); #1;
    if (port) begin bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; end
    else begin bus.if_req = 1'b1; bus.if_addr = addr; end
    lat = 0; en_cnt = 0; we_cnt = 0; other = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin en_cnt++; chk("txn mem_addr", bus.mem_addr, addr); end
      if (bus.mem_we) we_cnt++;
      if (port ? bus.if_ack : bus.d_ack) other++;
      if (port ? bus.d_ack : bus.if_ack) break;
      lat++;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
    bit          exp_last;
  } vec_t;
  vec_t vecs[6];

  // reference model: arbiter free time, round-robin pointer, shadow memory
  bit          model_on = 1'b0;
  bit          m_started = 1'b0;
  int          m_free;
  bit          m_ptr;
  bit          w;
  bit          m_exp_en;
  int          m_ack[2];
  logic [31:0] m_rd[2];
  logic [31:0] m_pend[2];
  bit          m_pend_rd[2];
  logic [31:0] m_addr;
  bit          m_we;
  logic [31:0] m_wd;
  logic [31:0] sh [0:255];

  always @(negedge clk) begin
    if (model_on) begin
      if (!m_started) begin
        m_started = 1'b1; m_free = cyc; m_ptr = 1'b1;
        m_ack = '{-1, -1}; m_rd = '{32'h0, 32'h0}; m_pend_rd = '{1'b0, 1'b0};
        m_addr = '0; m_we = 1'b0; m_wd = '0;
        for (int i = 0; i < 256; i++) sh[i] = mem[i];
      end
      for (int p = 0; p < 2; p++) if (m_ack[p] == cyc && m_pend_rd[p]) m_rd[p] = m_pend[p];
      m_exp_en = (cyc == m_free - 3);
      chk("rand if_ack", 32'(bus.if_ack), 32'(m_ack[0] == cyc));
      chk("rand d_ack", 32'(bus.d_ack), 32'(m_ack[1] == cyc));
      chk("rand busy", 32'(bus.busy), 32'(cyc < m_free));
      chk("rand last_gnt", 32'(bus.last_gnt), 32'(m_ptr));
      chk("rand mem_en", 32'(bus.mem_en), 32'(m_exp_en));
      chk("rand mem_we", 32'(bus.mem_we), 32'(m_exp_en && m_we));
      if (m_exp_en) chk("rand mem_addr", bus.mem_addr, m_addr);
      if (m_exp_en && m_we) chk("rand mem_wdata", bus.mem_wdata, m_wd);
      chk("rand if_rdata", bus.if_rdata, m_rd[0]);
      chk("rand d_rdata", bus.d_rdata, m_rd[1]);
      if (cyc >= m_free && (bus.if_req || bus.d_req)) begin
        w = (bus.if_req && bus.d_req) ? !m_ptr : bus.d_req;
        m_ptr = w;
        m_free = cyc + 4;
        m_ack[w] = cyc + 3;
        m_addr = w ? bus.d_addr : bus.if_addr;
        m_we = w && bus.d_we;
        m_wd = bus.d_wdata;
        if (m_we) begin sh[m_addr[9:2]] = m_wd; m_pend_rd[w] = 1'b0; end
        else begin m_pend[w] = sh[m_addr[9:2]]; m_pend_rd[w] = 1'b1; end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, en_cnt, we_cnt, other, ia, da, k, cnt, ackt;
    int seq_port[4];
    int seq_t[4];
    bit ia_seen, da_seen;
    logic [3:0] r;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h00500093, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h00500093, 32'h0,        1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'h00500093, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h80, 32'h0,        32'h12345678, 32'hDEADBEEF, 1'b0};

    do_reset();
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
    chk("reset mem_en/we", 32'({bus.mem_en, bus.mem_we}), 32'd0);
    chk("reset last_gnt", 32'(bus.last_gnt), 32'd1);
    chk("reset if_rdata", bus.if_rdata, 32'h0);
    chk("reset d_rdata", bus.d_rdata, 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset mem_wdata", bus.mem_wdata, 32'h0);

    preload(32'h10, 32'h00500093);
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, en_cnt, we_cnt, other);
      chk($sformatf("vec%0d ack latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d mem_en cycles", i), 32'(en_cnt), 32'd1);
      chk($sformatf("vec%0d mem_we cycles", i), 32'(we_cnt), 32'(vecs[i].we));
      chk($sformatf("vec%0d other ack", i), 32'(other), 32'd0);
      chk($sformatf("vec%0d if_rdata", i), bus.if_rdata, vecs[i].exp_if_rdata);
      chk($sformatf("vec%0d d_rdata", i), bus.d_rdata, vecs[i].exp_d_rdata);
      chk($sformatf("vec%0d last_gnt", i), 32'(bus.last_gnt), 32'(vecs[i].exp_last));
    end

    // contention right after reset: fetch first, data 4 cycles later
    do_reset();
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    ia = -1; da = -1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (t == 1) chk("contention last_gnt first", 32'(bus.last_gnt), 32'd0);
      if (t == 5) chk("contention last_gnt second", 32'(bus.last_gnt), 32'd1);
      if (bus.if_ack) ia = t;
      if (bus.d_ack) da = t;
      @(posedge clk); #1;
      if (ia == t) bus.if_req = 1'b0;
      if (da == t) bus.d_req = 1'b0;
    end
    chk("contention if_ack cycle", 32'(ia), 32'd3);
    chk("contention d_ack cycle", 32'(da), 32'd7);
    chk("contention if_rdata", bus.if_rdata, 32'h00500093);
    chk("contention d_rdata", bus.d_rdata, 32'hDEADBEEF);
    idle_inputs();

    // fairness: data keeps requesting, fetch arrives during a data transaction
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    k = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if ((bus.if_ack || bus.d_ack) && k < 4) begin
        seq_port[k] = bus.d_ack ? 1 : 0;
        seq_t[k] = t;
        k++;
      end
      @(posedge clk); #1;
      if (t == 0) begin bus.if_req = 1'b1; bus.if_addr = 32'h10; end
    end
    idle_inputs();
    chk("fair ack count", 32'(k), 32'd4);
    for (int j = 0; j < 4 && j < k; j++) begin
      chk($sformatf("fair grant %0d port", j), 32'(seq_port[j]), 32'((j % 2) == 0));
      chk($sformatf("fair grant %0d cycle", j), 32'(seq_t[j]), 32'(3 + 4 * j));
    end

    // reset during the access cycle of a write
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'hCAFEF00D;
    @(posedge clk); #2;
    chk("rstmid mem_we before reset", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("rstmid mem_we", 32'(bus.mem_we), 32'd0);
    chk("rstmid mem_en", 32'(bus.mem_en), 32'd0);
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    chk("rstmid last_gnt", 32'(bus.last_gnt), 32'd1);
    chk("rstmid if_rdata", bus.if_rdata, 32'h0);
    chk("rstmid d_rdata", bus.d_rdata, 32'h0);
    chk("rstmid mem_addr", bus.mem_addr, 32'h0);
    chk("rstmid mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (bus.d_ack || bus.if_ack) cnt++;
    end
    chk("rstmid no ack", 32'(cnt), 32'd0);
    chk("rstmid memory untouched", mem[32], 32'h12345678);

    // requester drops req and changes address right after the grant
    preload(32'h20, 32'h11111111);
    preload(32'h24, 32'h22222222);
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    cnt = 0; ackt = -1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t == 1) begin
        chk("early mem_en", 32'(bus.mem_en), 32'd1);
        chk("early mem_addr", bus.mem_addr, 32'h20);
      end
      if (bus.d_ack) begin cnt++; ackt = t; end
      @(posedge clk); #1;
      if (t == 0) begin bus.d_req = 1'b0; bus.d_addr = 32'h24; end
    end
    idle_inputs();
    chk("early ack count", 32'(cnt), 32'd1);
    chk("early ack cycle", 32'(ackt), 32'd3);
    chk("early d_rdata", bus.d_rdata, 32'h11111111);

    // random traffic against the model
    do_reset();
    model_on = 1'b1;
    ia_seen = 1'b0; da_seen = 1'b0;
    for (int t = 0; t < 800; t++) begin
      if (!bus.if_req || ia_seen) begin
        if ((bus.if_req && $urandom_range(1) == 0) || (!bus.if_req && $urandom_range(2) == 0)) begin
          r = 4'($urandom_range(15));
          bus.if_req = 1'b1; bus.if_addr = {26'd0, r, 2'b00};
        end else bus.if_req = 1'b0;
      end
      if (!bus.d_req || da_seen) begin
        if ((bus.d_req && $urandom_range(1) == 0) || (!bus.d_req && $urandom_range(2) == 0)) begin
          r = 4'($urandom_range(15));
          bus.d_req = 1'b1; bus.d_addr = {26'd0, r, 2'b00};
          bus.d_we = 1'($urandom_range(1)); bus.d_wdata = $urandom;
        end else bus.d_req = 1'b0;
      end
      @(negedge clk);
      ia_seen = bus.if_ack;
      da_seen = bus.d_ack;
      @(posedge clk); #1;
    end
    model_on = 1'b0;
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that lets the multi-cycle core's instruction-fetch path and load/store path share one single-port, synchronous-read memory. It sits between the control unit's fetch/memory-access steps and the physical memory, serializing requests with a req/ack handshake and round-robin priority. Every transaction, read or write, completes with a fixed 3-cycle latency.

## Interface
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetch read data; valid while if_ack=1, held afterwards
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load data; valid while d_ack=1 for reads, unchanged by writes
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid the cycle after an enabled read
- busy  out  1  1 when state != IDLE
- last_gnt  out  1  round-robin pointer: 0 = fetch last granted, 1 = data last granted

## Operation
- FSM states: IDLE -> ACC -> CAP -> DONE -> IDLE. There are no other transitions, except that rst forces IDLE.
- IDLE: the arbiter samples if_req and d_req. If neither is asserted, it stays in IDLE. If exactly one is asserted, that port wins. If both are asserted, the port opposite last_gnt wins.
- On a grant, the arbiter registers the winner id, the address, the write flag (always 0 for fetch) and the write data. It updates last_gnt to the winner and moves to ACC.
- ACC: mem_en=1, mem_we=latched write flag, and mem_addr/mem_wdata come from the latched values. The memory samples the access at the end of this cycle.
- CAP: mem_en=0 and mem_we=0. At the end of the cycle, mem_rdata is captured into the winner's rdata register, but only for reads.
- DONE: the winner's ack=1 for exactly this cycle. The loser's ack stays 0.
- Requester inputs are latched at the grant. Changes to addr/wdata/we after the grant do not affect the transaction in flight.
- The requester must drop req, or present a new request, in the cycle after ack. A req still high in the following IDLE starts a new transaction.
- If req is dropped before ack (a protocol violation), the transaction still completes and ack still pulses.
- A port that loses arbitration keeps waiting. Round-robin priority guarantees it is granted next, so the wait is at most one transaction (4 cycles) behind the other port.
- rdata registers hold their value between transactions. A write never changes d_rdata or if_rdata.

## Timing
- Reset values: state IDLE; if_ack, d_ack, mem_en, mem_we, busy = 0; if_rdata, d_rdata, mem_addr, mem_wdata = 0; last_gnt = 1, so fetch wins the first contended grant.
- All outputs are registered. None is combinational from an input.
- Latency: a req sampled high in IDLE cycle n gives mem_en=1 in cycle n+1, mem_rdata in n+2, and ack with rdata in n+3. The next grant is possible at n+4.
- Throughput: 1 transaction per 4 cycles. busy=1 in cycles n+1 through n+3.
- Reset is asynchronous and takes effect mid-operation. The FSM returns to IDLE and mem_en, mem_we and the acks drop to 0 immediately. A write in ACC may be truncated, and the transaction is aborted with no ack.
- The first IDLE sample after reset is released happens on the first rising clock edge with rst=0.

## Test plan
- Single fetch: if_req=1, if_addr=0x10, memory[0x10]=0x00500093. Required: mem_en=1 and mem_addr=0x10 one cycle after the grant, if_ack pulse 3 cycles after the grant with if_rdata=0x00500093, d_ack=0 throughout, last_gnt=0.
- Data write then read: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF. Required: mem_we=1 for exactly one cycle and d_ack at +3 with d_rdata unchanged. A following read of 0x40 returns d_rdata=0xDEADBEEF with d_ack.
- Contention after reset: if_req and d_req rise together. Required: fetch is served first. d is served in the next IDLE, with d_ack exactly 4 cycles after if_ack. last_gnt sequence is 0 then 1.
- Fairness: d_req held high continuously (re-requesting) while if_req rises during a data transaction. Required: fetch is granted next, and grants alternate D, I, D, I.
- Reset mid-write: assert rst during ACC of a write to 0x80. Required: mem_we and mem_en drop to 0 without waiting for a clock, no d_ack is produced, busy=0, last_gnt=1, and all data outputs are 0.
- Early drop and input change: d_req falls and d_addr changes in the cycle after the grant. Required: the access still uses the original address, and d_ack still pulses once at +3.
